// File: rtl/floo_vc_input_buffer.sv
// floo_vc_input_buffer: per-VC circular flit buffers with credit return; FLOO_VC_BUF_CREDIT_REG_EN registers the credit output
module floo_vc_input_buffer #(
  parameter int unsigned NumVC = 4,
  parameter int unsigned VCDepth = 2,
  parameter type flit_t = logic,
  parameter type flit_payload_t = logic,
  parameter type hdr_t = logic,
  parameter int unsigned VCIdW = NumVC > 1 ? $clog2(NumVC) : 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       valid_i,
  input  logic [VCIdW-1:0]           vc_id_i,
  input  flit_t                      flit_i,
  output flit_payload_t              vc_data_head_o [NumVC],
  output hdr_t                       vc_ctrl_head_o [NumVC],
  output logic [NumVC-1:0]           vc_not_empty_o,
  input  logic                       read_valid_i,
  input  logic [NumVC-1:0]           read_vc_id_oh_i,
  output logic                       credit_valid_o,
  output logic [VCIdW-1:0]           credit_id_o,
  output logic                       err_o
);
  localparam int unsigned FW = $bits(flit_t);
  localparam int unsigned PW = $bits(flit_payload_t);
  localparam int unsigned HW = $bits(hdr_t);
  localparam int unsigned PtrW = VCDepth > 1 ? $clog2(VCDepth) : 1;
  localparam int unsigned CntW = $clog2(VCDepth + 1);

  logic [FW-1:0]    mem [NumVC][VCDepth];
  logic [PtrW-1:0]  wr_ptr [NumVC];
  logic [PtrW-1:0]  rd_ptr [NumVC];
  logic [CntW-1:0]  cnt [NumVC];
  logic [NumVC-1:0] push_req, push, pop;
  logic [VCIdW-1:0] pop_id;
  logic             sel_one, sel_multi, err_d;

  function automatic logic [PtrW-1:0] nxt(input logic [PtrW-1:0] p);
    return p == PtrW'(VCDepth - 1) ? '0 : p + 1'b1;
  endfunction

  assign sel_one   = read_valid_i && $onehot(read_vc_id_oh_i);
  assign sel_multi = read_valid_i && !$onehot0(read_vc_id_oh_i);

  for (genvar v = 0; v < NumVC; v++) begin : g_vc
    assign push_req[v]       = valid_i && vc_id_i == VCIdW'(v);
    assign pop[v]            = sel_one && read_vc_id_oh_i[v] && cnt[v] != '0;
    assign push[v]           = push_req[v] && (cnt[v] != CntW'(VCDepth) || pop[v]);
    assign vc_not_empty_o[v] = cnt[v] != '0;
    assign vc_data_head_o[v] = flit_payload_t'(mem[v][rd_ptr[v]][PW-1:0]);
    assign vc_ctrl_head_o[v] = hdr_t'(mem[v][rd_ptr[v]][FW-1 -: HW]);
  end

  assign err_d = (valid_i && push == '0) || (sel_one && pop == '0) || sel_multi;

  // index of the VC popped this cycle, used as the credit id
  always_comb begin
    pop_id = '0;
    for (int i = 0; i < NumVC; i++) pop_id = pop[i] ? VCIdW'(i) : pop_id;
  end

  // per-VC storage, pointers, occupancy and the sticky error flag
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumVC; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        cnt[i]    <= '0;
        for (int j = 0; j < VCDepth; j++) mem[i][j] <= '0;
      end
      err_o <= 1'b0;
    end else begin
      for (int i = 0; i < NumVC; i++) begin
        if (push[i]) begin
          mem[i][wr_ptr[i]] <= flit_i;
          wr_ptr[i]         <= nxt(wr_ptr[i]);
        end
        if (pop[i]) rd_ptr[i] <= nxt(rd_ptr[i]);
        cnt[i] <= cnt[i] + CntW'(push[i]) - CntW'(pop[i]);
      end
      err_o <= err_o | err_d;
    end
  end

`ifdef FLOO_VC_BUF_CREDIT_REG_EN
  // credit returned one cycle after the pop
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      credit_valid_o <= 1'b0;
      credit_id_o    <= '0;
    end else begin
      credit_valid_o <= |pop;
      credit_id_o    <= pop_id;
    end
  end
`else
  assign credit_valid_o = |pop;
  assign credit_id_o    = pop_id;
`endif
endmodule
